pipeline_stall_ctrl: RTL and testbench

Central stall/flush controller for the MiniMIPS32 five-stage pipeline. Combines hazard stall requests from ID and EXE with a multi-cycle divider handshake. Drives one stall vector to the PC and to every inter-stage register (IF/ID, ID/EXE, EXE/MEM, MEM/WB), plus a flush when MEM raises an exception. Also keeps a saturating stall-cycle performance counter.

---
 rtl/pipeline_stall_ctrl.sv | 100 ++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_ctrl
// Description : MiniMIPS32 stall/flush controller with divider handshake FSM
//               and a saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             cpu_clk_50M,
    input  logic             cpu_rst,
    input  logic             id_stallreq,
    input  logic             exe_stallreq,
    input  logic             exe_div_req,
    input  logic             div_ready,
    input  logic             mem_exc_req,
    input  logic [31:0]      mem_exc_vec,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             div_start,
    output logic             div_cancel,
    output logic             div_result_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } div_state_t;

    localparam logic [5:0] STALL_EXE = 6'b001111;
    localparam logic [5:0] STALL_ID  = 6'b000111;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_stall;
    logic             div_active;

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        div_active     = (state_q == START) || (state_q == BUSY);
        div_stall      = div_active || ((state_q == IDLE) && exe_div_req);
        flush          = mem_exc_req && !cpu_rst;
        new_pc         = flush ? mem_exc_vec : 32'd0;
        stall          = 6'b000000;
        div_start      = 1'b0;
        div_cancel     = 1'b0;
        div_result_sel = 1'b0;

        if (!cpu_rst) begin
            if (flush)
                stall = 6'b000000;
            else if (div_stall || exe_stallreq)
                stall = STALL_EXE;
            else if (id_stallreq)
                stall = STALL_ID;

            // An exception aborts an in-flight divide before it can start or finish.
            div_cancel     = flush && div_active;
            div_start      = (state_q == START) && !flush;
            div_result_sel = (state_q == DONE);
        end

        case (state_q)
            IDLE:  if (exe_div_req && !flush) state_d = START;
            START: state_d = flush ? IDLE : BUSY;
            BUSY: begin
                if (flush)
                    state_d = IDLE;
                else if (div_ready)
                    state_d = DONE;
            end
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cnt_d = cnt_q;
        if ((stall != 6'b000000) && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_ONE;
    end

    assign stall_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_stall_ctrl
// Description : Table-driven directed bench for pipeline_stall_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_ctrl;

    typedef struct {
        logic        rst, id, exe, dreq, drdy, exc;
        logic [31:0] vec;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
        logic        e_start, e_cancel, e_sel;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, id, exe, dreq, drdy, exc;
    logic [31:0] evec;
    logic [5:0]  stall;
    logic        flush, dstart, dcancel, dsel;
    logic [31:0] new_pc;
    logic [31:0] cnt;

    logic        sat_id;
    logic [5:0]  sat_stall;
    logic        sat_flush, sat_start, sat_cancel, sat_sel;
    logic [31:0] sat_pc;
    logic [3:0]  sat_cnt;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl[$];

    always #10 clk = ~clk;

    pipeline_stall_ctrl u_dut (
        .cpu_clk_50M   (clk),
        .cpu_rst       (rst),
        .id_stallreq   (id),
        .exe_stallreq  (exe),
        .exe_div_req   (dreq),
        .div_ready     (drdy),
        .mem_exc_req   (exc),
        .mem_exc_vec   (evec),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .div_start     (dstart),
        .div_cancel    (dcancel),
        .div_result_sel(dsel),
        .stall_cnt     (cnt)
    );

    pipeline_stall_ctrl #(.CNT_W(4)) u_sat (
        .cpu_clk_50M   (clk),
        .cpu_rst       (rst),
        .id_stallreq   (sat_id),
        .exe_stallreq  (1'b0),
        .exe_div_req   (1'b0),
        .div_ready     (1'b0),
        .mem_exc_req   (1'b0),
        .mem_exc_vec   (32'd0),
        .stall         (sat_stall),
        .flush         (sat_flush),
        .new_pc        (sat_pc),
        .div_start     (sat_start),
        .div_cancel    (sat_cancel),
        .div_result_sel(sat_sel),
        .stall_cnt     (sat_cnt)
    );

    task automatic add(input logic r, i, e, q, d, x, input logic [31:0] v,
                       input logic [5:0] es, input logic ef, input logic [31:0] ep,
                       input logic est, ec, esl);
        vec_t t;
        t.rst = r; t.id = i; t.exe = e; t.dreq = q; t.drdy = d; t.exc = x; t.vec = v;
        t.e_stall = es; t.e_flush = ef; t.e_pc = ep;
        t.e_start = est; t.e_cancel = ec; t.e_sel = esl;
        tbl.push_back(t);
    endtask

    localparam logic [31:0] V1 = 32'hBFC0_0380;
    localparam logic [31:0] V2 = 32'h8000_0180;

    initial begin
        logic [31:0] m_cnt;
        rst = 1'b1; id = 0; exe = 0; dreq = 0; drdy = 0; exc = 0; evec = 0; sat_id = 0;

        //   rst id exe req rdy exc vec     stall      fl pc   st cn sel
        add(1, 1, 0, 1, 0, 1, V1,       6'b000000, 0, 0,   0, 0, 0);  // outputs masked in reset
        for (int k = 0; k < 10; k++)
            add(0, 0, 0, 0, 0, 0, 0,    6'b000000, 0, 0,   0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0,        6'b000111, 0, 0,   0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0,        6'b000111, 0, 0,   0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,        6'b000000, 0, 0,   0, 0, 0);
        // divide: request at T, ready at T+5, result select at T+6
        add(0, 0, 0, 1, 0, 0, 0,        6'b001111, 0, 0,   0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0,        6'b001111, 0, 0,   1, 0, 0);  // ready ignored in START
        add(0, 0, 0, 1, 0, 0, 0,        6'b001111, 0, 0,   0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0,        6'b001111, 0, 0,   0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0,        6'b001111, 0, 0,   0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0,        6'b001111, 0, 0,   0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0,        6'b000000, 0, 0,   0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0,        6'b000000, 0, 0,   0, 0, 0);  // stray ready in IDLE
        // flush in BUSY, then restart proves IDLE, then flush in START
        add(0, 0, 0, 1, 0, 0, 0,        6'b001111, 0, 0,   0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0,        6'b001111, 0, 0,   1, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0,        6'b001111, 0, 0,   0, 0, 0);
        add(0, 0, 0, 1, 0, 1, V1,       6'b000000, 1, V1,  0, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0,        6'b001111, 0, 0,   0, 0, 0);
        add(0, 0, 0, 1, 0, 1, V2,       6'b000000, 1, V2,  0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0,        6'b000000, 0, 0,   0, 0, 0);
        // flush in IDLE blocks the divide start
        add(0, 0, 0, 1, 0, 1, V1,       6'b000000, 1, V1,  0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,        6'b000000, 0, 0,   0, 0, 0);
        // priority between hazards and flush
        add(0, 1, 1, 0, 0, 0, 0,        6'b001111, 0, 0,   0, 0, 0);
        add(0, 1, 1, 0, 0, 1, V2,       6'b000000, 1, V2,  0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0,        6'b001111, 0, 0,   0, 0, 0);
        // flush in DONE still drives result select, no cancel
        add(0, 0, 0, 1, 0, 0, 0,        6'b001111, 0, 0,   0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0,        6'b001111, 0, 0,   1, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0,        6'b001111, 0, 0,   0, 0, 0);
        add(0, 0, 0, 1, 0, 1, V1,       6'b000000, 1, V1,  0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0,        6'b000000, 0, 0,   0, 0, 0);
        // back-to-back divides
        add(0, 0, 0, 1, 0, 0, 0,        6'b001111, 0, 0,   0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0,        6'b001111, 0, 0,   1, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0,        6'b001111, 0, 0,   0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0,        6'b000000, 0, 0,   0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0,        6'b001111, 0, 0,   0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0,        6'b001111, 0, 0,   1, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0,        6'b001111, 0, 0,   0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,        6'b000000, 0, 0,   0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0,        6'b000000, 0, 0,   0, 0, 0);
        // reset in the middle of a divide
        add(0, 0, 0, 1, 0, 0, 0,        6'b001111, 0, 0,   0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0,        6'b001111, 0, 0,   1, 0, 0);
        add(1, 0, 0, 1, 0, 1, V1,       6'b000000, 0, 0,   0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,        6'b000000, 0, 0,   0, 0, 0);

        repeat (2) @(posedge clk);
        m_cnt = 32'd0;
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            rst = tbl[i].rst; id = tbl[i].id; exe = tbl[i].exe; dreq = tbl[i].dreq;
            drdy = tbl[i].drdy; exc = tbl[i].exc; evec = tbl[i].vec;
            @(negedge clk);
            n_vec++;
            if (stall !== tbl[i].e_stall || flush !== tbl[i].e_flush ||
                new_pc !== tbl[i].e_pc || dstart !== tbl[i].e_start ||
                dcancel !== tbl[i].e_cancel || dsel !== tbl[i].e_sel || cnt !== m_cnt) begin
                n_err++;
                $display("FAIL vec%0d got stall=%b flush=%b pc=%h start=%b cancel=%b sel=%b cnt=%0d, expected stall=%b flush=%b pc=%h start=%b cancel=%b sel=%b cnt=%0d",
                         i, stall, flush, new_pc, dstart, dcancel, dsel, cnt,
                         tbl[i].e_stall, tbl[i].e_flush, tbl[i].e_pc, tbl[i].e_start,
                         tbl[i].e_cancel, tbl[i].e_sel, m_cnt);
            end
            if (tbl[i].rst)
                m_cnt = 32'd0;
            else if (tbl[i].e_stall != 6'b000000)
                m_cnt = m_cnt + 32'd1;
        end

        // 4-bit counter saturation under 20 continuous stall cycles
        @(posedge clk); #1;
        rst = 0; id = 0; exe = 0; dreq = 0; drdy = 0; exc = 0; evec = 0;
        for (int k = 0; k <= 20; k++) begin
            @(posedge clk); #1;
            sat_id = (k < 20);
            @(negedge clk);
            n_vec++;
            if (sat_cnt !== 4'((k > 15) ? 15 : k) ||
                sat_stall !== ((k < 20) ? 6'b000111 : 6'b000000)) begin
                n_err++;
                $display("FAIL sat%0d got cnt=%0d stall=%b, expected cnt=%0d stall=%b",
                         k, sat_cnt, sat_stall, (k > 15) ? 15 : k,
                         (k < 20) ? 6'b000111 : 6'b000000);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
